mac_loop_sequencer: RTL and testbench

Parametrised job sequencer for the MAC HWPE that replaces microcode-driven address generation with NB_LOOPS nested hardware loop counters. It sits between the register file/slave and the streamers/engine inside the control block. Per job, it issues one address command per innermost iteration to the streamers, bounds in-flight commands, waits for engine completions and raises a done event.

---
 rtl/mac_loop_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_mac_loop_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_loop_sequencer.sv
// Job sequencer for the MAC HWPE: nested hardware loop counters generate one address command per innermost iteration.
// Optional performance counters are built only when MAC_SEQ_PERF_CNT_EN is defined.
module mac_loop_sequencer #(
  parameter int N_STREAMS = 3,
  parameter int NB_LOOPS  = 2,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [N_STREAMS*ADDR_W-1:0]          base_i,
  input  logic [NB_LOOPS*N_STREAMS*ADDR_W-1:0] jump_i,
  input  logic [NB_LOOPS*CNT_W-1:0]            range_i,
  input  logic [CNT_W-1:0]                     len_i,
  output logic                                 cmd_valid_o,
  input  logic                                 cmd_ready_i,
  output logic [N_STREAMS*ADDR_W-1:0]          cmd_addr_o,
  output logic [CNT_W-1:0]                     cmd_len_o,
  output logic                                 cmd_last_o,
  input  logic                                 eng_done_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic [NB_LOOPS*CNT_W-1:0]            idx_o,
  output logic [31:0]                          perf_cycles_o,
  output logic [31:0]                          perf_stalls_o
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int LVL_W = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] ONE_OUT   = OUT_W'(32'd1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                               state_r, state_s;
  logic [NB_LOOPS*N_STREAMS*ADDR_W-1:0] jump_r;
  logic [NB_LOOPS*CNT_W-1:0]            range_r;
  logic [NB_LOOPS*CNT_W-1:0]            idx_r, idx_s;
  logic [N_STREAMS*ADDR_W-1:0]          addr_r, addr_s;
  logic [CNT_W-1:0]                     len_r;
  logic [OUT_W-1:0]                     out_r, out_s;
  logic                                 err_r, err_s;
  logic                                 valid_s, hs_s, adv_found_s, start_s;
  logic [LVL_W-1:0]                     adv_lvl_s;

  assign start_s = (state_r == IDLE) && start_i;
  assign valid_s = (state_r == ISSUE) && (out_r < MAX_OUT_C);
  assign hs_s    = valid_s && cmd_ready_i;

  // Lowest level still below its range is the one that advances; none means last command
  always_comb begin
    adv_found_s = 1'b0;
    adv_lvl_s   = '0;
    for (int l = 0; l < NB_LOOPS; l++) begin
      if (!adv_found_s && (idx_r[l*CNT_W +: CNT_W] < range_r[l*CNT_W +: CNT_W])) begin
        adv_found_s = 1'b1;
        adv_lvl_s   = LVL_W'(l);
      end else begin
        adv_found_s = adv_found_s;
      end
    end
  end

  // Next loop indices and stream addresses on an accepted command
  always_comb begin
    idx_s  = idx_r;
    addr_s = addr_r;
    if (hs_s && adv_found_s) begin
      for (int l = 0; l < NB_LOOPS; l++) begin
        if (LVL_W'(l) < adv_lvl_s) begin
          idx_s[l*CNT_W +: CNT_W] = '0;
        end else if (LVL_W'(l) == adv_lvl_s) begin
          idx_s[l*CNT_W +: CNT_W] = idx_r[l*CNT_W +: CNT_W] + ONE_CNT;
        end else begin
          idx_s[l*CNT_W +: CNT_W] = idx_r[l*CNT_W +: CNT_W];
        end
      end
      for (int s = 0; s < N_STREAMS; s++) begin
        addr_s[s*ADDR_W +: ADDR_W] = addr_r[s*ADDR_W +: ADDR_W]
          + jump_r[(int'(adv_lvl_s) * N_STREAMS + s) * ADDR_W +: ADDR_W];
      end
    end else begin
      idx_s  = idx_r;
      addr_s = addr_r;
    end
  end

  // Outstanding command tracking; a completion with nothing in flight is flagged, not counted
  always_comb begin
    out_s = out_r;
    err_s = err_r;
    case ({hs_s, eng_done_i})
      2'b10:   out_s = out_r + ONE_OUT;
      2'b01: begin
        if (out_r == '0) begin
          out_s = out_r;
          err_s = 1'b1;
        end else begin
          out_s = out_r - ONE_OUT;
        end
      end
      default: out_s = out_r;
    endcase
  end

  // Job FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (hs_s && !adv_found_s) state_s = DRAIN;
        else                      state_s = ISSUE;
      end
      DRAIN: begin
        if (out_r == '0) state_s = DONE;
        else             state_s = DRAIN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, job configuration and loop registers; clear_i behaves exactly like reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_r <= IDLE;
      jump_r  <= '0;
      range_r <= '0;
      len_r   <= '0;
      addr_r  <= '0;
      idx_r   <= '0;
      out_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        jump_r  <= jump_i;
        range_r <= range_i;
        len_r   <= len_i;
        addr_r  <= base_i;
        idx_r   <= '0;
        out_r   <= '0;
        err_r   <= 1'b0;
      end else begin
        idx_r   <= idx_s;
        addr_r  <= addr_s;
        out_r   <= out_s;
        err_r   <= err_s;
      end
    end
  end

  assign cmd_valid_o = valid_s;
  assign cmd_addr_o  = addr_r;
  assign cmd_len_o   = len_r;
  assign cmd_last_o  = (state_r == ISSUE) && !adv_found_s;
  assign busy_o      = (state_r != IDLE);
  assign done_o      = (state_r == DONE);
  assign err_o       = err_r;
  assign idx_o       = idx_r;

`ifdef MAC_SEQ_PERF_CNT_EN
  logic [31:0] cyc_r, stall_r;

  // Saturating busy-cycle and stall counters, restarted per job
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i || start_s) begin
      cyc_r   <= 32'd0;
      stall_r <= 32'd0;
    end else begin
      if ((state_r != IDLE) && (cyc_r != 32'hFFFF_FFFF)) cyc_r <= cyc_r + 32'd1;
      else                                                 cyc_r <= cyc_r;
      if (valid_s && !cmd_ready_i && (stall_r != 32'hFFFF_FFFF)) stall_r <= stall_r + 32'd1;
      else                                                        stall_r <= stall_r;
    end
  end

  assign perf_cycles_o = cyc_r;
  assign perf_stalls_o = stall_r;
`else
  assign perf_cycles_o = 32'd0;
  assign perf_stalls_o = 32'd0;
`endif

endmodule

// File: tb/tb_mac_loop_sequencer.sv
// Directed self-checking bench for mac_loop_sequencer (instantiated with MAX_OUT=2).
// Perf-counter expectations follow MAC_SEQ_PERF_CNT_EN.
module tb_mac_loop_sequencer;
  localparam int NS = 3, NL = 2, AW = 32, CW = 16, MO = 2;

  logic             clk = 1'b0;
  logic             rst_ni, clear_i, start_i, cmd_ready_i, eng_done_i;
  logic [NS*AW-1:0] base_i;
  logic [NL*NS*AW-1:0] jump_i;
  logic [NL*CW-1:0] range_i;
  logic [CW-1:0]    len_i;
  logic             cmd_valid_o, cmd_last_o, busy_o, done_o, err_o;
  logic [NS*AW-1:0] cmd_addr_o;
  logic [CW-1:0]    cmd_len_o;
  logic [NL*CW-1:0] idx_o;
  logic [31:0]      perf_cycles_o, perf_stalls_o;

  int total = 0;
  int bad   = 0;

  mac_loop_sequencer #(.N_STREAMS(NS), .NB_LOOPS(NL), .ADDR_W(AW), .CNT_W(CW), .MAX_OUT(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_i(base_i), .jump_i(jump_i), .range_i(range_i), .len_i(len_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_addr_o(cmd_addr_o),
    .cmd_len_o(cmd_len_o), .cmd_last_o(cmd_last_o), .eng_done_i(eng_done_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .idx_o(idx_o),
    .perf_cycles_o(perf_cycles_o), .perf_stalls_o(perf_stalls_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] b0, b1, b2, j00, j01, j02, j10, j11, j12,
                         input logic [15:0] r0, r1, len);
    base_i  = {b2, b1, b0};
    jump_i  = {j12, j11, j10, j02, j01, j00};
    range_i = {r1, r0};
    len_i   = len;
  endtask

  task automatic pulse_start;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Retires the single remaining in-flight command and reports when done_o fires
  task automatic drain_job(output int dcnt, output int first_c);
    cmd_ready_i = 1'b0;
    eng_done_i  = 1'b1;
    tick();
    eng_done_i  = 1'b0;
    dcnt    = 0;
    first_c = -1;
    for (int c = 0; c < 8; c++) begin
      if (done_o) begin
        dcnt++;
        if (first_c < 0) first_c = c;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; cmd_ready_i = 1'b0; eng_done_i = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    total++;
    if ({cmd_valid_o, cmd_last_o, busy_o, done_o, err_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {cmd_valid_o, cmd_last_o, busy_o, done_o, err_o});
    end
    total++;
    if ({cmd_addr_o, cmd_len_o, idx_o} !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%h len=%h idx=%h want 0", cmd_addr_o, cmd_len_o, idx_o);
    end
    total++;
    if ({perf_cycles_o, perf_stalls_o} !== 64'd0) begin
      bad++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_cycles_o, perf_stalls_o);
    end
    rst_ni = 1'b1;
    tick();
    total++;
    if ({busy_o, cmd_valid_o} !== 2'b00) begin
      bad++; $display("FAIL post_reset_idle: got %b want 00", {busy_o, cmd_valid_o});
    end
  endtask

  task automatic test_single;
    int dcnt, fc;
    set_cfg(32'h100, 32'h200, 32'h300, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3, 16'd0, 16'd7);
    pulse_start();
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({cmd_valid_o, cmd_last_o} !== {1'b1, (i == 3)}) begin
        bad++; $display("FAIL single_vl[%0d]: got %b want %b", i, {cmd_valid_o, cmd_last_o}, {1'b1, (i == 3)});
      end
      total++;
      if (cmd_addr_o !== {32'h300, 32'h200 + 32'(8 * i), 32'h100 + 32'(4 * i)}) begin
        bad++; $display("FAIL single_addr[%0d]: got %h want s0=%h", i, cmd_addr_o, 32'h100 + 32'(4 * i));
      end
      total++;
      if ({idx_o, cmd_len_o} !== {16'd0, 16'(i), 16'd7}) begin
        bad++; $display("FAIL single_idx[%0d]: got idx=%h len=%h want idx0=%0d len=7", i, idx_o, cmd_len_o, i);
      end
      eng_done_i = (i > 0);
      tick();
    end
    eng_done_i = 1'b0;
    total++;
    if ({busy_o, cmd_valid_o} !== 2'b10) begin
      bad++; $display("FAIL single_drain: got busy,valid=%b want 10", {busy_o, cmd_valid_o});
    end
    drain_job(dcnt, fc);
    total++;
    if (dcnt !== 1 || fc !== 1) begin
      bad++; $display("FAIL single_done: got count=%0d at=%0d want count=1 at=1", dcnt, fc);
    end
    total++;
    if ({busy_o, err_o} !== 2'b00) begin
      bad++; $display("FAIL single_idle: got busy,err=%b want 00", {busy_o, err_o});
    end
  endtask

  task automatic test_nested;
    int dcnt, fc;
    logic [31:0] exp0 [6] = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h80, 32'h84};
    logic [31:0] exp1 [6] = '{32'h1000, 32'h1001, 32'h1000, 32'h1001, 32'h1000, 32'h1001};
    set_cfg(32'h0, 32'h1000, 32'h2000, 32'h4, 32'h1, 32'h0, 32'h3C, 32'hFFFF_FFFF, 32'h0, 16'd1, 16'd2, 16'd1);
    pulse_start();
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (cmd_addr_o !== {32'h2000, exp1[i], exp0[i]}) begin
        bad++; $display("FAIL nested_addr[%0d]: got %h want s1=%h s0=%h", i, cmd_addr_o, exp1[i], exp0[i]);
      end
      total++;
      if ({idx_o, cmd_valid_o, cmd_last_o} !== {16'(i / 2), 16'(i % 2), 1'b1, (i == 5)}) begin
        bad++; $display("FAIL nested_idx[%0d]: got idx=%h v/l=%b%b want idx1=%0d idx0=%0d", i, idx_o,
                        cmd_valid_o, cmd_last_o, i / 2, i % 2);
      end
      eng_done_i = (i > 0);
      tick();
    end
    eng_done_i = 1'b0;
    drain_job(dcnt, fc);
    total++;
    if (dcnt !== 1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL nested_done: got count=%0d busy=%b want 1 0", dcnt, busy_o);
    end
  endtask

  task automatic test_backpressure;
    int dcnt, fc;
    bit saw;
    logic [31:0] la0, la1;
    set_cfg(32'h0, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 16'd4, 16'd0, 16'd2);
    pulse_start();
    cmd_ready_i = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_valid_o !== 1'b0) begin
      bad++; $display("FAIL bp_full: got valid=%b want 0", cmd_valid_o);
    end
    base_i  = {3{32'hDEAD_0000}};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    total++;
    if ({cmd_valid_o, cmd_addr_o[31:0]} !== {1'b0, 32'h2}) begin
      bad++; $display("FAIL bp_hold: got valid=%b a0=%h want 0 2", cmd_valid_o, cmd_addr_o[31:0]);
    end
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    cmd_ready_i = 1'b0;
    total++;
    if (cmd_valid_o !== 1'b1) begin
      bad++; $display("FAIL bp_reraise: got valid=%b want 1", cmd_valid_o);
    end
    tick();
    total++;
    if ({cmd_valid_o, cmd_addr_o[31:0], idx_o[15:0]} !== {1'b1, 32'h2, 16'd2}) begin
      bad++; $display("FAIL bp_stall_stable: got v=%b a0=%h idx0=%h want 1 2 2", cmd_valid_o,
                      cmd_addr_o[31:0], idx_o[15:0]);
    end
    saw = 1'b0; la0 = '0; la1 = '0;
    for (int k = 0; k < 10; k++) begin
      cmd_ready_i = 1'b1;
      eng_done_i  = 1'b1;
      if (cmd_valid_o && cmd_last_o) begin
        saw = 1'b1; la0 = cmd_addr_o[31:0]; la1 = cmd_addr_o[63:32];
        tick();
        break;
      end
      tick();
    end
    eng_done_i = 1'b0;
    total++;
    if ({saw, la0, la1} !== {1'b1, 32'h4, 32'h8}) begin
      bad++; $display("FAIL bp_last: got saw=%b a0=%h a1=%h want 1 4 8", saw, la0, la1);
    end
    drain_job(dcnt, fc);
    total++;
    if (dcnt !== 1) begin
      bad++; $display("FAIL bp_done: got %0d want 1", dcnt);
    end
  endtask

  task automatic test_same_cycle;
    set_cfg(32'h10, 32'h20, 32'h30, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1, 16'd0, 16'd1);
    pulse_start();
    cmd_ready_i = 1'b1;
    tick();
    eng_done_i = 1'b1;
    total++;
    if ({cmd_valid_o, cmd_last_o} !== 2'b11) begin
      bad++; $display("FAIL sc_last: got %b want 11", {cmd_valid_o, cmd_last_o});
    end
    tick();
    cmd_ready_i = 1'b0;
    total++;
    if ({busy_o, cmd_valid_o} !== 2'b10) begin
      bad++; $display("FAIL sc_drain: got %b want 10", {busy_o, cmd_valid_o});
    end
    tick();
    total++;
    if ({err_o, done_o} !== 2'b00) begin
      bad++; $display("FAIL sc_no_err_yet: got err,done=%b want 00", {err_o, done_o});
    end
    tick();
    eng_done_i = 1'b0;
    total++;
    if ({err_o, done_o} !== 2'b11) begin
      bad++; $display("FAIL sc_err_done: got err,done=%b want 11", {err_o, done_o});
    end
    tick();
    total++;
    if ({busy_o, err_o, done_o} !== 3'b010) begin
      bad++; $display("FAIL sc_sticky: got busy,err,done=%b want 010", {busy_o, err_o, done_o});
    end
  endtask

  task automatic test_clear;
    int dcnt, fc;
    set_cfg(32'h1000, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 16'd3, 16'd1, 16'd5);
    pulse_start();
    total++;
    if ({err_o, cmd_valid_o} !== 2'b01) begin
      bad++; $display("FAIL clr_start_err: got err,valid=%b want 01", {err_o, cmd_valid_o});
    end
    cmd_ready_i = 1'b1;
    tick();
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    cmd_ready_i = 1'b0;
    total++;
    if ({busy_o, cmd_valid_o, idx_o, cmd_addr_o} !== '0) begin
      bad++; $display("FAIL clr_state: got busy=%b valid=%b idx=%h addr=%h want 0", busy_o, cmd_valid_o,
                      idx_o, cmd_addr_o);
    end
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_o) dcnt++;
      tick();
    end
    total++;
    if (dcnt !== 0) begin
      bad++; $display("FAIL clr_no_done: got %0d want 0", dcnt);
    end
    set_cfg(32'h500, 32'h0, 32'h0, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1, 16'd0, 16'd3);
    pulse_start();
    total++;
    if ({cmd_valid_o, cmd_addr_o[31:0], idx_o} !== {1'b1, 32'h500, 32'h0}) begin
      bad++; $display("FAIL clr_restart: got v=%b a0=%h idx=%h want 1 500 0", cmd_valid_o,
                      cmd_addr_o[31:0], idx_o);
    end
    cmd_ready_i = 1'b1;
    tick();
    total++;
    if ({cmd_last_o, cmd_addr_o[31:0]} !== {1'b1, 32'h510}) begin
      bad++; $display("FAIL clr_second: got last=%b a0=%h want 1 510", cmd_last_o, cmd_addr_o[31:0]);
    end
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
    drain_job(dcnt, fc);
    total++;
    if (dcnt !== 1 || fc !== 1) begin
      bad++; $display("FAIL clr_done: got count=%0d at=%0d want 1 1", dcnt, fc);
    end
  endtask

  task automatic test_perf;
    int dcnt, fc;
    set_cfg(32'h40, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3, 16'd0, 16'd1);
    pulse_start();
    for (int k = 0; k < 7; k++) begin
      cmd_ready_i = (k >= 3);
      eng_done_i  = (k >= 4);
      if (k == 1) begin
        total++;
        if ({cmd_valid_o, cmd_addr_o[31:0], idx_o} !== {1'b1, 32'h40, 32'h0}) begin
          bad++; $display("FAIL perf_stall_hold: got v=%b a0=%h idx=%h want 1 40 0", cmd_valid_o,
                          cmd_addr_o[31:0], idx_o);
        end
      end
      if (k == 6) begin
        total++;
        if ({cmd_last_o, cmd_addr_o[31:0]} !== {1'b1, 32'h4C}) begin
          bad++; $display("FAIL perf_last: got last=%b a0=%h want 1 4c", cmd_last_o, cmd_addr_o[31:0]);
        end
      end
      tick();
    end
    eng_done_i = 1'b0;
    cmd_ready_i = 1'b0;
`ifdef MAC_SEQ_PERF_CNT_EN
    total++;
    if ({perf_cycles_o, perf_stalls_o} !== {32'd7, 32'd3}) begin
      bad++; $display("FAIL perf_counts: got cycles=%0d stalls=%0d want 7 3", perf_cycles_o, perf_stalls_o);
    end
`else
    total++;
    if ({perf_cycles_o, perf_stalls_o} !== 64'd0) begin
      bad++; $display("FAIL perf_tied: got cycles=%0d stalls=%0d want 0 0", perf_cycles_o, perf_stalls_o);
    end
`endif
    drain_job(dcnt, fc);
    total++;
    if (dcnt !== 1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL perf_done: got count=%0d busy=%b want 1 0", dcnt, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nested();
    test_backpressure();
    test_same_cycle();
    test_clear();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
